vout_mode_ctrl: RTL and testbench

VOUT_MODE_CTRL -- requirements
Module: vout_mode_ctrl

---
 rtl/vout_pkg.sv | 48 ++++
 rtl/vout_mode_tbl.sv | 56 +++++
 rtl/vout_mode_ctrl.sv | 132 +++++++++++++
 tb/tb_vout_mode_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vout_pkg.sv
// -----------------------------------------------------------------------------
// vout_pkg
// Shared definitions for the video output mode controller:
//   - table field codes (low two bits of the configuration address)
//   - mode-change FSM encoding
//   - reset timing constants loaded into every table entry and the outputs
//   - timing record type and a validity helper
// -----------------------------------------------------------------------------
package vout_pkg;

    localparam logic [1:0] FLD_PIX  = 2'd0;
    localparam logic [1:0] FLD_LINE = 2'd1;
    localparam logic [1:0] FLD_HS   = 2'd2;
    localparam logic [1:0] FLD_VS   = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_APPLY = 2'd2,
        ST_ACK   = 2'd3
    } vout_state_e;

    localparam logic [15:0] RST_PIX  = 16'd330;
    localparam logic [15:0] RST_LINE = 16'd100;
    localparam logic [15:0] RST_HS   = 16'd16;
    localparam logic [15:0] RST_VS   = 16'd4;

    typedef struct packed {
        logic [15:0] pix;
        logic [15:0] line;
        logic [15:0] hs;
        logic [15:0] vs;
    } vout_timing_t;

    localparam vout_timing_t RST_TIMING = '{
        pix:  RST_PIX,
        line: RST_LINE,
        hs:   RST_HS,
        vs:   RST_VS
    };

    // A mode is usable only if none of its four fields is zero.
    function automatic logic timing_valid(input vout_timing_t t);
        return (t.pix != 16'd0) && (t.line != 16'd0) &&
               (t.hs != 16'd0) && (t.vs != 16'd0);
    endfunction

endpackage

// File: rtl/vout_mode_tbl.sv
// -----------------------------------------------------------------------------
// vout_mode_tbl
// Register-based MODE_NUM x 4 x 16-bit timing table, one write port and one
// read port. The read port returns a whole entry (all four fields) and is
// combinational, so a write lands on the clock edge and is visible from the
// next cycle; a reader in the same cycle sees the pre-write contents.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (loads RST_TIMING)
//   wr_en         : write strobe
//   wr_addr       : {mode index, field code}
//   wr_data       : 16-bit field value
//   rd_idx        : mode index to read
//   rd_entry      : the four fields of entry rd_idx
// -----------------------------------------------------------------------------
module vout_mode_tbl
    import vout_pkg::*;
#(
    parameter int MODE_NUM = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(MODE_NUM)+1:0]   wr_addr,
    input  logic [15:0]                   wr_data,
    input  logic [$clog2(MODE_NUM)-1:0]   rd_idx,
    output vout_timing_t                  rd_entry
);

    localparam int IW = $clog2(MODE_NUM);

    vout_timing_t mem [MODE_NUM];

    logic [IW-1:0] wr_idx;
    logic [1:0]    wr_fld;

    assign wr_idx = wr_addr[IW+1:2];
    assign wr_fld = wr_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MODE_NUM; i++) begin
                mem[i] <= RST_TIMING;
            end
        end else if (wr_en) begin
            case (wr_fld)
                FLD_PIX:  mem[wr_idx].pix  <= wr_data;
                FLD_LINE: mem[wr_idx].line <= wr_data;
                FLD_HS:   mem[wr_idx].hs   <= wr_data;
                default:  mem[wr_idx].vs   <= wr_data;
            endcase
        end
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/vout_mode_ctrl.sv
// -----------------------------------------------------------------------------
// vout_mode_ctrl
// Holds a table of display timing modes and switches the active timing only
// on a frame boundary. A request latches the mode index, waits for the next
// vs_i rising edge, then checks the entry and either loads all four timing
// outputs plus mode_cur_o together or rejects the request. Completion is a
// one-cycle mode_ack_o with mode_err_o qualifying it.
//
// Handshake: mode_req_i is a level held by the requester until it sees
// mode_ack_o high; the ack cycle is the only cycle the result is valid. If
// mode_req_i is still high after the ack cycle, a new request is latched.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_wr_i/addr_i/data_i   : table write port, addr = {mode, field}
//   mode_sel_i, mode_req_i   : requested mode index and request level
//   mode_ack_o, mode_err_o   : completion pulse and reject flag
//   vs_i                     : vertical sync from the timing generator
//   pix/line/hs/vs_count_o   : active timing presented to the generator
//   mode_cur_o               : index of the active mode
//   frame_cnt_o              : vs_i rising edges since reset (wrapping)
//   state_dbg_o              : current FSM state (vout_state_e encoding)
// -----------------------------------------------------------------------------
module vout_mode_ctrl
    import vout_pkg::*;
#(
    parameter int MODE_NUM   = 4,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_wr_i,
    input  logic [$clog2(MODE_NUM)+1:0]   cfg_addr_i,
    input  logic [15:0]                   cfg_data_i,
    input  logic [$clog2(MODE_NUM)-1:0]   mode_sel_i,
    input  logic                          mode_req_i,
    output logic                          mode_ack_o,
    output logic                          mode_err_o,
    input  logic                          vs_i,
    output logic [15:0]                   pix_count_o,
    output logic [15:0]                   line_count_o,
    output logic [15:0]                   hs_count_o,
    output logic [15:0]                   vs_count_o,
    output logic [$clog2(MODE_NUM)-1:0]   mode_cur_o,
    output logic [FCNT_WIDTH-1:0]         frame_cnt_o,
    output logic [1:0]                    state_dbg_o
);

    localparam int IW = $clog2(MODE_NUM);

    vout_state_e           state_q, state_d;
    logic                  vs_d;
    logic                  frame_evt;
    logic [IW-1:0]         sel_q;
    logic [IW-1:0]         cur_q;
    logic                  err_q;
    logic [FCNT_WIDTH-1:0] fcnt_q;
    vout_timing_t          timing_q;
    vout_timing_t          tbl_entry;

    vout_mode_tbl #(
        .MODE_NUM (MODE_NUM)
    ) u_tbl (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cfg_wr_i),
        .wr_addr  (cfg_addr_i),
        .wr_data  (cfg_data_i),
        .rd_idx   (sel_q),
        .rd_entry (tbl_entry)
    );

    assign frame_evt = vs_i & ~vs_d;

    always_comb begin
        state_d    = state_q;
        mode_ack_o = 1'b0;
        mode_err_o = 1'b0;
        case (state_q)
            ST_RUN:   if (mode_req_i) state_d = ST_PEND;
            ST_PEND:  if (frame_evt) state_d = ST_APPLY;
            ST_APPLY: state_d = ST_ACK;
            ST_ACK: begin
                mode_ack_o = 1'b1;
                mode_err_o = err_q;
                state_d    = ST_RUN;
            end
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            vs_d     <= 1'b0;
            fcnt_q   <= '0;
            sel_q    <= '0;
            cur_q    <= '0;
            err_q    <= 1'b0;
            timing_q <= RST_TIMING;
        end else begin
            state_q <= state_d;
            vs_d    <= vs_i;
            if (frame_evt) begin
                fcnt_q <= fcnt_q + {{(FCNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (state_q == ST_RUN && mode_req_i) begin
                sel_q <= mode_sel_i;
            end
            // The table read here sees pre-write contents even if the same
            // entry is being written this cycle.
            if (state_q == ST_APPLY) begin
                if (timing_valid(tbl_entry)) begin
                    timing_q <= tbl_entry;
                    cur_q    <= sel_q;
                    err_q    <= 1'b0;
                end else begin
                    err_q    <= 1'b1;
                end
            end
        end
    end

    assign pix_count_o  = timing_q.pix;
    assign line_count_o = timing_q.line;
    assign hs_count_o   = timing_q.hs;
    assign vs_count_o   = timing_q.vs;
    assign mode_cur_o   = cur_q;
    assign frame_cnt_o  = fcnt_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_vout_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vout_mode_ctrl
// Directed bench for vout_mode_ctrl. Each request pushes its expected
// {err, mode_cur, pix, line, hs, vs} into exp_q; a monitor pops and compares
// on every mode_ack_o. A second instance with FCNT_WIDTH=4 shares all inputs
// and is used only for its frame counter wrap.
// -----------------------------------------------------------------------------
module tb_vout_mode_ctrl;
    import vout_pkg::*;

    localparam int EW = 1 + 2 + 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_wr_i = 1'b0;
    logic [3:0]  cfg_addr_i = '0;
    logic [15:0] cfg_data_i = '0;
    logic [1:0]  mode_sel_i = '0;
    logic        mode_req_i = 1'b0;
    logic        vs_i = 1'b0;

    logic        mode_ack_o, mode_err_o;
    logic [15:0] pix_count_o, line_count_o, hs_count_o, vs_count_o;
    logic [1:0]  mode_cur_o;
    logic [15:0] frame_cnt_o;
    logic [1:0]  state_dbg_o;

    logic        ack4, err4;
    logic [15:0] pix4, line4, hs4, vsc4;
    logic [1:0]  cur4, st4;
    logic [3:0]  fcnt4;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    int n_vec = 0;
    int n_err = 0;
    int ack_seen = 0;
    int fc_exp = 0;

    logic [15:0] cur_pix = 16'd330, cur_line = 16'd100, cur_hs = 16'd16, cur_vs = 16'd4;
    logic [1:0]  cur_mode = 2'd0;

    always #5 clk = ~clk;

    vout_mode_ctrl dut (
        .clk(clk), .rst(rst), .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i),
        .cfg_data_i(cfg_data_i), .mode_sel_i(mode_sel_i), .mode_req_i(mode_req_i),
        .mode_ack_o(mode_ack_o), .mode_err_o(mode_err_o), .vs_i(vs_i),
        .pix_count_o(pix_count_o), .line_count_o(line_count_o),
        .hs_count_o(hs_count_o), .vs_count_o(vs_count_o),
        .mode_cur_o(mode_cur_o), .frame_cnt_o(frame_cnt_o), .state_dbg_o(state_dbg_o)
    );

    vout_mode_ctrl #(.FCNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i),
        .cfg_data_i(cfg_data_i), .mode_sel_i(mode_sel_i), .mode_req_i(mode_req_i),
        .mode_ack_o(ack4), .mode_err_o(err4), .vs_i(vs_i),
        .pix_count_o(pix4), .line_count_o(line4),
        .hs_count_o(hs4), .vs_count_o(vsc4),
        .mode_cur_o(cur4), .frame_cnt_o(fcnt4), .state_dbg_o(st4)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && mode_ack_o) begin
            ack_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 128'(1), 128'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_resp",
                      128'({mode_err_o, mode_cur_o, pix_count_o, line_count_o, hs_count_o, vs_count_o}),
                      128'(mon_e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name);
        check({name, "_pix"},  128'(pix_count_o),  128'(cur_pix));
        check({name, "_line"}, 128'(line_count_o), 128'(cur_line));
        check({name, "_hs"},   128'(hs_count_o),   128'(cur_hs));
        check({name, "_vs"},   128'(vs_count_o),   128'(cur_vs));
        check({name, "_cur"},  128'(mode_cur_o),   128'(cur_mode));
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [1:0] fld, input logic [15:0] d);
        tick();
        cfg_wr_i   = 1'b1;
        cfg_addr_i = {idx, fld};
        cfg_data_i = d;
        tick();
        cfg_wr_i   = 1'b0;
    endtask

    task automatic vs_pulse();
        tick();
        vs_i = 1'b1;
        fc_exp++;
        tick();
        tick();
        vs_i = 1'b0;
        tick();
    endtask

    // Issue a request, hold it mid-frame, raise vs_i and measure ack latency.
    // wr_apply writes pix of mode 'sel' during the APPLY cycle.
    task automatic do_request(input string name, input logic [1:0] sel,
                              input logic [15:0] e_pix, input logic [15:0] e_line,
                              input logic [15:0] e_hs, input logic [15:0] e_vs,
                              input logic e_err, input logic [1:0] e_cur,
                              input bit wr_apply, input logic [15:0] wr_pix, input bit keep);
        int lat;
        bit got;
        exp_q.push_back({e_err, e_cur, e_pix, e_line, e_hs, e_vs});
        tick();
        mode_sel_i = sel;
        mode_req_i = 1'b1;
        repeat (3) tick();
        check({name, "_pend_state"}, 128'(state_dbg_o), 128'(ST_PEND));
        check_outputs({name, "_midframe"});
        vs_i = 1'b1;
        fc_exp++;
        got = 0;
        lat = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mode_ack_o) begin
                got = 1;
                lat = c;
                break;
            end
            if (c == 1) check_outputs({name, "_apply"});
            tick();
            cfg_wr_i = 1'b0;
            if (c == 0 && wr_apply) begin
                cfg_wr_i   = 1'b1;
                cfg_addr_i = {sel, FLD_PIX};
                cfg_data_i = wr_pix;
            end
        end
        if (!keep) mode_req_i = 1'b0;
        check({name, "_ack_seen"}, 128'(got), 128'(1));
        check({name, "_ack_latency"}, 128'(lat), 128'(2));
        if (!e_err) begin
            cur_pix = e_pix; cur_line = e_line; cur_hs = e_hs; cur_vs = e_vs; cur_mode = e_cur;
        end
        tick();
        vs_i = 1'b0;
        tick();
        check_outputs({name, "_after"});
        check({name, "_fcnt"}, 128'(frame_cnt_o), 128'(fc_exp));
    endtask

    initial begin
        int acks_before;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_outputs("reset");
        check("reset_fcnt", 128'(frame_cnt_o), 128'(0));
        check("reset_ack", 128'(mode_ack_o), 128'(0));
        check("reset_state", 128'(state_dbg_o), 128'(ST_RUN));

        // Mode 1 = 640/480/32/8, applied at the next frame.
        cfg_write(2'd1, FLD_PIX, 16'd640);
        cfg_write(2'd1, FLD_LINE, 16'd480);
        cfg_write(2'd1, FLD_HS, 16'd32);
        cfg_write(2'd1, FLD_VS, 16'd8);
        do_request("m1", 2'd1, 16'd640, 16'd480, 16'd32, 16'd8, 1'b0, 2'd1, 0, 16'd0, 0);

        // Mode 2 with a zero line count is rejected; outputs stay on mode 1.
        cfg_write(2'd2, FLD_LINE, 16'd0);
        do_request("m2_err", 2'd2, 16'd640, 16'd480, 16'd32, 16'd8, 1'b1, 2'd1, 0, 16'd0, 0);

        // Write during APPLY is not seen; re-request picks it up.
        do_request("m1_wr", 2'd1, 16'd640, 16'd480, 16'd32, 16'd8, 1'b0, 2'd1, 1, 16'd800, 0);
        do_request("m1_re", 2'd1, 16'd800, 16'd480, 16'd32, 16'd8, 1'b0, 2'd1, 0, 16'd0, 0);

        // Mode 3, request kept high through ack re-latches; reset then drops it.
        cfg_write(2'd3, FLD_PIX, 16'd1024);
        cfg_write(2'd3, FLD_LINE, 16'd768);
        cfg_write(2'd3, FLD_HS, 16'd48);
        cfg_write(2'd3, FLD_VS, 16'd6);
        do_request("m3", 2'd3, 16'd1024, 16'd768, 16'd48, 16'd6, 1'b0, 2'd3, 0, 16'd0, 1);
        check("relatch_state", 128'(state_dbg_o), 128'(ST_PEND));
        acks_before = ack_seen;
        rst = 1'b1;
        mode_req_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        fc_exp = 0;
        cur_pix = 16'd330; cur_line = 16'd100; cur_hs = 16'd16; cur_vs = 16'd4; cur_mode = 2'd0;
        @(negedge clk);
        check("rst_pend_state", 128'(state_dbg_o), 128'(ST_RUN));
        check_outputs("rst_pend");
        check("rst_pend_fcnt", 128'(frame_cnt_o), 128'(0));

        // 17 frames: no ack may appear, narrow counter wraps to 1.
        repeat (17) vs_pulse();
        repeat (4) tick();
        check("no_ack_after_rst", 128'(ack_seen), 128'(acks_before));
        check("fcnt_17", 128'(frame_cnt_o), 128'(fc_exp));
        check("fcnt4_wrap", 128'(fcnt4), 128'(1));
        check("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
